// File: rtl/bcd_serializer_pkg.sv
// Shared definitions for the binary-to-BCD digit serializer: FSM encoding,
// BCD digit geometry and the double-dabble add-3 correction.
package bcd_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_EMIT    = 2'd2
  } state_t;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] ADD3_THRESH = 4'd5;

  // A digit >= 5 would exceed 9 after doubling; pre-add 3 so the shift carries into the next digit.
  function automatic logic [BCD_W-1:0] add3_adjust(input logic [BCD_W-1:0] digit);
    return (digit >= ADD3_THRESH) ? digit + 4'd3 : digit;
  endfunction

endpackage

// File: rtl/dabble_step.sv
// One double-dabble iteration: add 3 to every BCD digit >= 5, then shift
// the combined {bcd, bin} register left by one bit.
module dabble_step
  import bcd_serializer_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic [BCD_W*DIGITS+WIDTH-1:0] cur,
  output logic [BCD_W*DIGITS+WIDTH-1:0] nxt
);

  logic [BCD_W*DIGITS+WIDTH-1:0] adjusted;

  // Each digit is corrected in isolation; no carry crosses digit boundaries before the shift.
  always_comb begin
    adjusted = cur;
    for (int d = 0; d < DIGITS; d++) begin
      adjusted[WIDTH+d*BCD_W +: BCD_W] = add3_adjust(cur[WIDTH+d*BCD_W +: BCD_W]);
    end
  end

  assign nxt = adjusted << 1;

endmodule

// File: rtl/bcd_serializer.sv
// Converts one binary word to packed BCD with a sequential double-dabble and
// streams the digits MSD first over valid/ready with first/last framing.
module bcd_serializer
  import bcd_serializer_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       out_bcd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_first,
  output logic             out_last
);

  localparam int TOT_W = BCD_W*DIGITS + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t                      state, next_state;
  logic [TOT_W-1:0]            shift_q, shift_nxt;
  logic [CNT_W-1:0]            step_cnt;
  logic [IDX_W-1:0]            digit_idx;
  logic [BCD_W*DIGITS-1:0]     bcd;
  logic [BCD_W-1:0]            sel_digit;
  logic                        last_step;
  logic                        transfer;

  dabble_step #(
    .WIDTH (WIDTH),
    .DIGITS(DIGITS)
  ) u_dabble_step (
    .cur(shift_q),
    .nxt(shift_nxt)
  );

  assign bcd       = shift_q[TOT_W-1 -: BCD_W*DIGITS];
  assign last_step = (step_cnt == CNT_W'(1));
  assign transfer  = (state == ST_EMIT) && out_ready;

  // NOTE: non-blocking assignments so every register samples pre-edge values, whatever the statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (in_valid) next_state = ST_CONVERT;
      ST_CONVERT: if (last_step) next_state = ST_EMIT;
      ST_EMIT:    if (transfer && digit_idx == '0) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q   <= '0;
      step_cnt  <= '0;
      digit_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            shift_q  <= {{(BCD_W*DIGITS){1'b0}}, in_data};
            step_cnt <= CNT_W'(WIDTH);
          end
        end
        ST_CONVERT: begin
          shift_q  <= shift_nxt;
          step_cnt <= step_cnt - CNT_W'(1);
          if (last_step) digit_idx <= IDX_W'(DIGITS - 1);
        end
        ST_EMIT: begin
          if (transfer && digit_idx != '0) digit_idx <= digit_idx - IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Digit mux is purely combinational so a stall holds out_bcd exactly as long as the index holds.
  always_comb begin
    sel_digit = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (digit_idx == IDX_W'(d)) sel_digit = bcd[d*BCD_W +: BCD_W];
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_EMIT);
  assign out_bcd   = out_valid ? sel_digit : 4'd0;
  assign out_first = out_valid && (digit_idx == IDX_W'(DIGITS - 1));
  assign out_last  = out_valid && (digit_idx == '0);

endmodule
